// File: rtl/prim_mem_pkg.sv
// Shared encodings for the Prim memory controller.
package prim_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    CAP,
    ACK
  } state_e;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_BYTE = 2'b01;
  localparam logic [1:0] BS_WORD = 2'b11;

endpackage

// File: rtl/prim_mem_ctrl.sv
// Prim CPU bus to byte-wide sync RAM bridge, 16-bit accesses split LE.
// Optional PRIM_MEMCTRL_WAIT_EN stretches each RAM slot by WAIT_CYCLES.
module prim_mem_ctrl
  import prim_mem_pkg::*;
#(
  parameter int AW          = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [15:0]   i_addr,
  input  logic [15:0]   i_dat,
  output logic [15:0]   o_dat,
  input  logic [1:0]    i_bs,
  input  logic          i_we,
  output logic          o_ack,
  output logic [AW-1:0] o_ram_addr,
  output logic [7:0]    o_ram_dat,
  input  logic [7:0]    i_ram_dat,
  output logic          o_ram_en,
  output logic          o_ram_we
);

  state_e state_q, state_d;
  logic word_q, word_d;
  logic we_q, we_d;
  logic [15:0] dat_q, dat_d;
  logic [15:0] addr;
  logic ram_en, ram_we;
  logic last;
  logic first;

`ifdef PRIM_MEMCTRL_WAIT_EN
  localparam logic [15:0] WC = 16'(WAIT_CYCLES);
  logic [15:0] cnt_q, cnt_d;

  assign last  = (cnt_q == 16'd0);
  assign first = (cnt_q == WC);

  // Reload on every slot entry, count down to the final cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = WC;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_wait;
  assign unused_wait = (WAIT_CYCLES != 0);
  assign last  = 1'b1;
  assign first = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    we_d      = we_q;
    dat_d     = dat_q;
    addr      = 16'd0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    o_ram_dat = 8'd0;
    o_ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_bs != BS_NONE) begin
          state_d = ACC0;
          word_d  = (i_bs == BS_WORD);
          we_d    = i_we;
        end
      end
      ACC0: begin
        ram_en    = 1'b1;
        addr      = i_addr;
        ram_we    = i_we & last;
        o_ram_dat = i_dat[7:0];
        if (last) begin
          if (word_q)    state_d = ACC1;
          else if (we_q) state_d = ACK;
          else           state_d = CAP;
        end
      end
      ACC1: begin
        ram_en    = 1'b1;
        addr      = i_addr + 16'd1;
        ram_we    = i_we & last;
        o_ram_dat = i_dat[15:8];
        // Low byte from the ACC0 read arrives in the first ACC1 cycle.
        if (!we_q && first) dat_d[7:0] = i_ram_dat;
        if (last) state_d = we_q ? ACK : CAP;
      end
      CAP: begin
        if (word_q) dat_d = {i_ram_dat, dat_q[7:0]};
        else        dat_d = {8'h00, i_ram_dat};
        state_d = ACK;
      end
      ACK: begin
        o_ack   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      word_q  <= 1'b0;
      we_q    <= 1'b0;
      dat_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
    end
  end

  // Reset kills the RAM strobes in its own cycle so an abort writes nothing.
  assign o_ram_en   = ram_en & ~i_reset;
  assign o_ram_we   = ram_we & ~i_reset;
  assign o_ram_addr = addr[AW-1:0];
  assign o_dat      = dat_q;

endmodule

// File: doc/prim_mem_ctrl.md
Name: prim_mem_ctrl

Overview:
Bus slave that serves the Prim CPU memory bus: byte addressing, byte-select, a request held until acknowledged.
Bridges each CPU request to a byte-wide synchronous RAM with 1-cycle read latency. A 16-bit access becomes two byte accesses, little-endian, with no alignment restriction.
Sits directly downstream of the CPU core: drives its i_ack and i_dat, and consumes its o_addr, o_dat, o_bs and o_we.

Parameters:
AW, 16, RAM address width; o_ram_addr = byte address[AW-1:0].
WAIT_CYCLES, 0, extra cycles per byte access slot (used only with PRIM_MEMCTRL_WAIT_EN).

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_addr  in  16  CPU byte address
i_dat  in  16  CPU write data
o_dat  out  16  read data to CPU
i_bs  in  2  byte select: 00 idle, 01 byte, 11 word, 10 treated as 01
i_we  in  1  write strobe
o_ack  out  1  one-cycle completion pulse
o_ram_addr  out  AW  RAM byte address
o_ram_dat  out  8  RAM write data
i_ram_dat  in  8  RAM read data, valid the cycle after en
o_ram_en  out  1  RAM access enable
o_ram_we  out  1  RAM write enable

Behaviour:
- Clock i_clk; reset i_reset, synchronous, active-high.
- Reset values: state IDLE, o_ack=0, o_dat=0, o_ram_en=0, o_ram_we=0.
- Reset mid-operation aborts immediately. The next cycle is IDLE with no RAM enable and no ack.
- Request = i_bs!=0. The CPU holds i_addr, i_dat, i_bs and i_we stable until o_ack.
- State machine states: IDLE, ACC0, ACC1, CAP, ACK.
- IDLE -> ACC0 when a request is present.
- ACC0 drives en=1, addr=i_addr, we=i_we, ram_dat=i_dat[7:0].
  - word -> ACC1
  - byte write -> ACK
  - byte read -> CAP
- ACC1 drives en=1, addr=i_addr+1 (16-bit wrap FFFF->0000), we=i_we, ram_dat=i_dat[15:8].
  - On a read, ACC1 latches i_ram_dat into o_dat[7:0].
  - Next state: write -> ACK, read -> CAP.
- CAP latches i_ram_dat: word read into o_dat[15:8]; byte read into o_dat[7:0] with o_dat[15:8]=0. CAP -> ACK.
- ACK drives o_ack=1 for exactly one cycle; ACK -> IDLE unconditionally.
  - A request seen in the following IDLE cycle is treated as new, so back-to-back CPU fetch/execute works.
- RAM-side outputs are combinational from state and CPU inputs; they are 0 in IDLE, CAP and ACK.
- o_dat is registered. It holds its value after ACK until the next read updates it; writes do not change o_dat.
- Latency, counted from the request cycle in IDLE = cycle 0; ack in cycle:
  - byte write 2
  - word write 3
  - byte read 3
  - word read 4
- If i_bs drops mid-transaction (protocol violation), the transaction still completes and acks.

Optional Feature:
PRIM_MEMCTRL_WAIT_EN:
- Defined: each ACC0/ACC1 slot lasts 1+WAIT_CYCLES cycles, using an internal down-counter reloaded on slot entry.
  - en and addr are held stable for the whole slot.
  - we is asserted only in the final cycle of the slot.
  - Read data capture follows the final cycle.
  - Each slot adds WAIT_CYCLES to the latency figures above.
- Undefined: no counter; WAIT_CYCLES ignored; single-cycle slots.

Decomposition:
- Shared package prim_mem_pkg:
  - state encoding constants (IDLE, ACC0, ACC1, CAP, ACK)
  - byte-select constants BS_NONE=2'b00, BS_BYTE=2'b01, BS_WORD=2'b11
- No sub-module; the wait counter stays inline, within 120-400 lines.

Test Plan:
1. Byte read: RAM[0x0010]=0xA5; i_addr=0x0010, bs=01, we=0 -> RAM en cycle 1 addr 0x10; o_ack cycle 3; o_dat=0x00A5.
2. Unaligned word read: RAM[0x0021]=0x34, RAM[0x0022]=0x12; i_addr=0x0021, bs=11 -> o_dat=0x1234; o_ack cycle 4.
3. Word write with wrap: i_addr=0xFFFF, i_dat=0xBEEF, bs=11, we=1 (AW=16) -> RAM[0xFFFF]=0xEF, RAM[0x0000]=0xBE; o_ack cycle 3; o_dat unchanged.
4. Back-to-back: fetch bs=01 at 0x0000 acked, new request bs=11 next cycle -> second transaction starts in the IDLE cycle after ACK; exactly one o_ack per request.
5. Reset mid-op: assert i_reset during ACC1 of a word write -> next cycle o_ram_en=0, o_ram_we=0, o_ack=0, o_dat=0; no second byte written.
6. PRIM_MEMCTRL_WAIT_EN, WAIT_CYCLES=2, byte write 0x55 to 0x0040 -> en high for 3 cycles; we only in the 3rd; o_ack cycle 4.
